// File: rtl/multichannel_delay_effect.sv
// Time-multiplexed N-channel delay: per-channel circular buffers share one single-port-pair RAM,
// with feedforward, feedback, ping-pong and bypass modes feeding a dry/wet mixer.
module multichannel_delay_effect #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 24,
  parameter int FB_WIDTH   = 8,
  parameter int MIX_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] audio_in,
  output logic [NUM_CH*DATA_WIDTH-1:0] audio_out,
  output logic                         audio_out_valid,
  input  logic [ADDR_WIDTH-1:0]        delay_samples,
  input  logic [FB_WIDTH-1:0]          feedback_amount,
  input  logic [MIX_WIDTH-1:0]         effect_amount,
  input  logic [1:0]                   mode,
  input  logic                         clear
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RAM_AW = CH_W + ADDR_WIDTH;
  localparam int DEPTH  = NUM_CH << ADDR_WIDTH;
  localparam int PW     = DATA_WIDTH + FB_WIDTH + 1;
  localparam int SW     = DATA_WIDTH + 2;
  localparam int MW     = DATA_WIDTH + MIX_WIDTH + 2;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_READ, S_DRAIN, S_MIX, S_OUT} state_t;

  function automatic logic signed [DATA_WIDTH:0] fb_scale(input logic signed [DATA_WIDTH-1:0] x,
                                                          input logic [FB_WIDTH-1:0] g);
    logic signed [PW-1:0] p;
    p = PW'(x) * PW'($signed({1'b0, g}));
    return (DATA_WIDTH+1)'(p >>> FB_WIDTH);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] x);
    logic [SW-DATA_WIDTH:0] top;
    top = x[SW-1:DATA_WIDTH-1];
    if (top == '0 || top == '1) return x[DATA_WIDTH-1:0];
    else if (x[SW-1])           return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                        return {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  // Convex blend: the result never leaves the sample range, so truncation is exact.
  function automatic logic signed [DATA_WIDTH-1:0] mix(input logic signed [DATA_WIDTH-1:0] dry,
                                                       input logic signed [DATA_WIDTH-1:0] tap,
                                                       input logic [MIX_WIDTH-1:0] e);
    logic [MIX_WIDTH:0]   w_dry;
    logic signed [MW-1:0] acc;
    w_dry = (MIX_WIDTH+1)'(1 << MIX_WIDTH) - {1'b0, e};
    acc   = MW'(dry) * MW'($signed({1'b0, w_dry})) + MW'(tap) * MW'($signed({1'b0, e}));
    return DATA_WIDTH'(acc >>> MIX_WIDTH);
  endfunction

  state_t                       state_q, state_d;
  logic [CH_W-1:0]              cnt_q, cnt_d, nxt_ch, rd_ch_q;
  logic [RAM_AW-1:0]            clr_q, clr_d, waddr, raddr;
  logic [ADDR_WIDTH-1:0]        wp_q, wp_d, rd_ptr, d_q;
  logic [FB_WIDTH-1:0]          g_q;
  logic [MIX_WIDTH-1:0]         e_q;
  logic [1:0]                   mode_q;
  logic                         accept, we, re, rd_pend_q, valid_q;
  logic signed [DATA_WIDTH-1:0] wdata, rdata_q, dry_cur, tap_cur, tap_x, buf_in, mix_cur;
  logic signed [DATA_WIDTH-1:0] dry_q [NUM_CH];
  logic signed [DATA_WIDTH-1:0] tap_q [NUM_CH];
  logic signed [DATA_WIDTH-1:0] mix_q [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0] audio_out_q;
  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  assign sample_ready    = (state_q == S_IDLE);
  assign accept          = sample_ready & sample_valid & ~clear;
  assign audio_out       = audio_out_q;
  assign audio_out_valid = valid_q;
  assign nxt_ch          = (cnt_q == CH_W'(NUM_CH - 1)) ? '0 : cnt_q + CH_W'(1);
  assign rd_ptr          = wp_q - d_q;
  assign raddr           = {cnt_q, rd_ptr};
  assign re              = (state_q == S_READ);
  assign dry_cur         = dry_q[cnt_q];
  assign tap_cur         = tap_q[cnt_q];
  assign tap_x           = tap_q[nxt_ch];

  always_comb begin
    buf_in = dry_cur;
    case (mode_q)
      2'd1:    buf_in = sat(SW'(dry_cur) + SW'(fb_scale(tap_cur, g_q)));
      2'd2:    buf_in = sat(SW'(dry_cur) + SW'(fb_scale(tap_x, g_q)));
      default: ;
    endcase
    mix_cur = (mode_q == 2'd3) ? dry_cur : mix(dry_cur, tap_cur, e_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    wp_d    = wp_q;
    we      = 1'b0;
    waddr   = {cnt_q, wp_q};
    wdata   = buf_in;
    case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = clr_q;
        wdata = '0;
        wp_d  = '0;
        clr_d = clr_q + RAM_AW'(1);
        if (clr_q == RAM_AW'(DEPTH - 1)) begin
          clr_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (clear) begin
          clr_d   = '0;
          state_d = S_CLEAR;
        end else if (accept) begin
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        cnt_d = cnt_q + CH_W'(1);
        if (cnt_q == CH_W'(NUM_CH - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_MIX;
      S_MIX: begin
        we    = 1'b1;
        cnt_d = cnt_q + CH_W'(1);
        if (cnt_q == CH_W'(NUM_CH - 1)) begin
          cnt_d   = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        wp_d    = wp_q + ADDR_WIDTH'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      clr_q       <= '0;
      wp_q        <= '0;
      valid_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      audio_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_q     <= clr_d;
      wp_q      <= wp_d;
      valid_q   <= (state_q == S_OUT);
      rd_pend_q <= re;
      if (state_q == S_OUT)
        for (int c = 0; c < NUM_CH; c++) audio_out_q[c*DATA_WIDTH +: DATA_WIDTH] <= mix_q[c];
    end
  end

  // Read data lands one cycle after its READ slot; the DRAIN slot catches the last channel.
  always_ff @(posedge clk) begin
    rd_ch_q <= cnt_q;
    if (accept) begin
      d_q    <= (delay_samples == '0) ? ADDR_WIDTH'(1) : delay_samples;
      g_q    <= feedback_amount;
      e_q    <= effect_amount;
      mode_q <= mode;
      for (int c = 0; c < NUM_CH; c++) dry_q[c] <= audio_in[c*DATA_WIDTH +: DATA_WIDTH];
    end
    if (rd_pend_q)          tap_q[rd_ch_q] <= rdata_q;
    if (state_q == S_MIX)   mix_q[cnt_q]   <= mix_cur;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q    <= mem[raddr];
  end
endmodule

// File: tb/tb_multichannel_delay_effect.sv
// Directed bench for multichannel_delay_effect (2 channels, 16-deep buffers, 16-bit samples).
module tb_multichannel_delay_effect;
  localparam int NUM_CH = 2, AW = 4, DW = 16, FBW = 8, MXW = 8;

  logic                 clk = 1'b0, rst_n = 1'b1, sample_valid = 1'b0, clear = 1'b0;
  logic                 sample_ready, audio_out_valid;
  logic [NUM_CH*DW-1:0] audio_in = '0;
  logic [NUM_CH*DW-1:0] audio_out;
  logic [AW-1:0]        delay_samples = '0;
  logic [FBW-1:0]       feedback_amount = '0;
  logic [MXW-1:0]       effect_amount = '0;
  logic [1:0]           mode = '0;

  int nchk = 0, npass = 0, nfail = 0;
  int cyc = 0, acc_cyc = 0;
  int eq0[$];
  int eq1[$];

  multichannel_delay_effect #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                              .FB_WIDTH(FBW), .MIX_WIDTH(MXW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .audio_in(audio_in), .audio_out(audio_out), .audio_out_valid(audio_out_valid),
    .delay_samples(delay_samples), .feedback_amount(feedback_amount),
    .effect_amount(effect_amount), .mode(mode), .clear(clear));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: each output frame is matched against the oldest pending expectation.
  always @(negedge clk) begin
    if (audio_out_valid === 1'b1) begin
      int pending;
      pending = eq0.size();
      check("valid_expected", pending > 0, 1);
      if (pending > 0) begin
        check("out_ch0", $signed(audio_out[DW-1:0]), eq0.pop_front());
        check("out_ch1", $signed(audio_out[2*DW-1:DW]), eq1.pop_front());
        check("latency", cyc - acc_cyc, 6);
      end
    end
  end

  task automatic send(input int x0, input int x1, input int e0, input int e1);
    int n;
    n = 0;
    @(negedge clk);
    audio_in = {DW'(x1), DW'(x0)};
    sample_valid = 1'b1;
    while (sample_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("accept_wait", n < 100, 1);
    eq0.push_back(e0);
    eq1.push_back(e1);
    @(posedge clk);
    #1 acc_cyc = cyc;
    sample_valid = 1'b0;
    n = 0;
    while (eq0.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("output_wait", n < 50, 1);
  endtask

  task automatic do_clear(input logic with_valid);
    int n;
    n = 0;
    @(negedge clk);
    clear = 1'b1;
    sample_valid = with_valid;
    @(negedge clk);
    clear = 1'b0;
    sample_valid = 1'b0;
    check("clear_ready_low", sample_ready, 0);
    while (sample_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("clear_cycles", n, 32);
  endtask

  task automatic reset_check();
    int bad;
    bad = 0;
    @(negedge clk);
    if (sample_ready !== 1'b0 || audio_out_valid !== 1'b0 || audio_out !== '0) bad++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k < 32 && sample_ready !== 1'b0) bad++;
      if (audio_out_valid !== 1'b0 || audio_out !== '0) bad++;
    end
    check("reset_quiet", bad, 0);
    check("reset_ready_rise", sample_ready, 1);
  endtask

  initial begin
    int hx0[4];
    int hx1[4];
    int prev, n;
    hx0 = '{1234, -32768, 32767, -1};
    hx1 = '{-5, 777, 0, -20000};
    prev = 0;

    #1 rst_n = 1'b0;
    reset_check();

    // Feedforward impulse
    mode = 2'd0; delay_samples = 3; effect_amount = 128; feedback_amount = 0;
    send(1000, 0, 500, 0);
    send(0, 0, 0, 0);
    send(0, 0, 0, 0);
    send(0, 0, 500, 0);
    send(0, 0, 0, 0);
    send(0, 0, 0, 0);

    // Feedback decay
    do_clear(1'b0);
    mode = 2'd1; delay_samples = 2; feedback_amount = 128; effect_amount = 255;
    send(1024, 0, 4, 0);
    send(0, 0, 0, 0);
    send(0, 0, 1020, 0);
    send(0, 0, 0, 0);
    send(0, 0, 510, 0);

    // Ping-pong
    do_clear(1'b0);
    mode = 2'd2; delay_samples = 1; feedback_amount = 255; effect_amount = 255;
    send(1024, 0, 4, 0);
    send(0, 0, 1020, 0);
    send(0, 0, 0, 1016);
    send(0, 0, 1012, 0);

    // Saturating feedback
    do_clear(1'b0);
    mode = 2'd1; delay_samples = 1; feedback_amount = 255; effect_amount = 255;
    send(30000, 0, 117, 0);
    send(30000, 0, 30000, 0);
    send(30000, 0, 32756, 0);
    effect_amount = 0;
    send(30000, 0, 30000, 0);

    // Bypass with sample_valid held high: one acceptance every 7 cycles
    mode = 2'd3; effect_amount = 200; delay_samples = 1;
    @(negedge clk);
    sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      audio_in = {DW'(hx1[i]), DW'(hx0[i])};
      n = 0;
      while (sample_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("held_accept_wait", n < 20, 1);
      eq0.push_back(hx0[i]);
      eq1.push_back(hx1[i]);
      @(posedge clk);
      #1 acc_cyc = cyc;
      if (i > 0) check("held_period", acc_cyc - prev, 7);
      prev = acc_cyc;
    end
    sample_valid = 1'b0;
    n = 0;
    while (eq0.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("held_drain", n < 50, 1);

    // Clear beats a same-cycle valid, then every previously written tap reads back zero
    do_clear(1'b1);
    mode = 2'd0; effect_amount = 255;
    delay_samples = 12; send(0, 0, 0, 0);
    delay_samples = 12; send(0, 0, 0, 0);
    delay_samples = 15; send(0, 0, 0, 0);

    // Delay 0 behaves as 1; negative values round toward minus infinity
    delay_samples = 0;
    send(512, -513, 2, -3);
    send(0, 0, 510, -511);

    // Reset during MIX discards the frame and restarts clearing
    mode = 2'd1;
    @(negedge clk);
    audio_in = {DW'(3), DW'(9)};
    sample_valid = 1'b1;
    n = 0;
    while (sample_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("midrst_accept_wait", n < 20, 1);
    @(posedge clk);
    #1 sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    check("midrst_valid_low", audio_out_valid, 0);
    reset_check();
    mode = 2'd3;
    send(7, -7, 7, -7);
    check("queue_empty", eq0.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
